// File: rtl/des_key_sched.sv
// Sequential DES key schedule: PC1 on load, then one PC2 round subkey per
// handshake, in forward (K1..K16) or reverse (K16..K1) order.
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Table entries use DES numbering: bit 1 is the MSB of the source vector.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_reg, state_next;
    logic [27:0] c_reg, c_next;
    logic [27:0] d_reg, d_next;
    logic [3:0]  round_reg, round_next;
    logic        dec_reg, dec_next;
    logic        done_reg, done_next;

    logic [55:0] pc1_key;
    logic [55:0] cd;
    logic [47:0] pc2_out;
    logic [4:0]  sched_n;
    logic        step_two;
    logic        transfer;
    logic        unused_parity;

    // Shift amount for key number n is 1 only at n = 1, 2, 9, 16.
    function automatic logic shift_is_two(input logic [4:0] n);
        return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[55 - gi] = key[64 - PC1_TAB[gi]];
        end
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign pc2_out[47 - gi] = cd[56 - PC2_TAB[gi]];
        end
    endgenerate

    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    assign cd           = {c_reg, d_reg};
    assign busy         = (state_reg == GEN);
    assign subkey_valid = (state_reg == GEN);
    assign subkey       = pc2_out;
    assign round        = round_reg;
    assign done         = done_reg;
    assign transfer     = subkey_valid && subkey_ready;

    // Key number whose shift moves us to the next subkey in emission order.
    assign sched_n  = dec_reg ? (5'd16 - {1'b0, round_reg}) : ({1'b0, round_reg} + 5'd2);
    assign step_two = shift_is_two(sched_n);

    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        round_next = round_reg;
        dec_next   = dec_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Decrypt starts unrotated: 28 total shifts make C16 == C0.
                    c_next     = decrypt ? pc1_key[55:28] : rot_left(pc1_key[55:28], 1'b0);
                    d_next     = decrypt ? pc1_key[27:0]  : rot_left(pc1_key[27:0], 1'b0);
                    round_next = 4'd0;
                    dec_next   = decrypt;
                    state_next = GEN;
                end
            end
            GEN: begin
                if (transfer) begin
                    if (round_reg == 4'd15) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        round_next = round_reg + 4'd1;
                        if (dec_reg) begin
                            c_next = rot_right(c_reg, step_two);
                            d_next = rot_right(d_reg, step_two);
                        end else begin
                            c_next = rot_left(c_reg, step_two);
                            d_next = rot_left(d_reg, step_two);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            round_reg <= '0;
            dec_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            round_reg <= round_next;
            dec_reg   <= dec_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized bench for des_key_sched against a bit-level DES key schedule model.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_ks [16];

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Textbook schedule: bit arrays numbered from 1, cumulative left shifts.
    task automatic ref_sched(input logic [63:0] k, input logic dec);
        int kb [1:64];
        int c  [1:28];
        int d  [1:28];
        logic [47:0] fwd [16];
        for (int i = 1; i <= 64; i++) kb[i] = int'(k[64 - i]);
        for (int i = 1; i <= 28; i++) begin
            c[i] = kb[PC1_T[i - 1]];
            d[i] = kb[PC1_T[i + 27]];
        end
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFTS[n]; s++) begin
                int tc = c[1];
                int td = d[1];
                for (int i = 1; i < 28; i++) begin
                    c[i] = c[i + 1];
                    d[i] = d[i + 1];
                end
                c[28] = tc;
                d[28] = td;
            end
            for (int j = 1; j <= 48; j++) begin
                int p = PC2_T[j - 1];
                fwd[n][48 - j] = (p <= 28) ? c[p][0] : d[p - 28][0];
            end
        end
        for (int n = 0; n < 16; n++) exp_ks[n] = dec ? fwd[15 - n] : fwd[n];
    endtask

    task automatic issue_start(input logic [63:0] k, input logic dec);
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Walk one schedule from its first valid cycle to the done cycle.
    task automatic run_body(input int stall_pct, input int poke_idx, input logic [63:0] poke_key);
        int idx = 0;
        int cyc = 0;
        bit poked = 0;
        while (idx < 16) begin
            if (cyc >= 1000) begin
                check("timeout_transfers", 64'(idx), 64'd16);
                break;
            end
            check("valid", 64'(subkey_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("done_mid", 64'(done), 64'd0);
            check("round", 64'(round), 64'(idx));
            check("subkey", 64'(subkey), 64'(exp_ks[idx]));
            subkey_ready = ($urandom_range(99) >= stall_pct);
            if (idx == poke_idx && !poked) begin
                poked   = 1;
                start   = 1'b1;
                key     = poke_key;
                decrypt = ~decrypt;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (subkey_ready) begin
                $display("xfer round %0d subkey %012h", idx, subkey_ready ? exp_ks[idx] : 48'h0);
                idx++;
            end
            cyc++;
        end
        subkey_ready = 1'b0;
        check("done_pulse", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("valid_end", 64'(subkey_valid), 64'd0);
    endtask

    task automatic done_falls();
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    localparam logic [63:0] KEY0   = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    initial begin
        logic [63:0] rk;
        logic        rd;
        int          n;

        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key          = '0;
        subkey_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known encrypt vectors, ready held high.
        ref_sched(KEY0, 1'b0);
        check("model_k1", 64'(exp_ks[0]), 64'h1B02EFFC7072);
        check("model_k2", 64'(exp_ks[1]), 64'h79AED9DBC9E5);
        check("model_k16", 64'(exp_ks[15]), 64'hCB3D8B0E17F5);
        issue_start(KEY0, 1'b0);
        run_body(0, -1, '0);
        done_falls();

        // Known decrypt vectors.
        ref_sched(KEY0, 1'b1);
        check("model_dec0", 64'(exp_ks[0]), 64'hCB3D8B0E17F5);
        check("model_dec14", 64'(exp_ks[14]), 64'h79AED9DBC9E5);
        check("model_dec15", 64'(exp_ks[15]), 64'h1B02EFFC7072);
        issue_start(KEY0, 1'b1);
        run_body(0, -1, '0);
        done_falls();

        // Backpressure in both directions.
        for (int dir = 0; dir < 2; dir++) begin
            ref_sched(KEY0, dir[0]);
            issue_start(KEY0, dir[0]);
            run_body(45, -1, '0);
            done_falls();
        end

        // Parity bits are ignored.
        ref_sched(KEY0, 1'b0);
        issue_start(KEY0 ^ PARITY, 1'b0);
        run_body(30, -1, '0);
        done_falls();
        issue_start(64'h123556789ABCDEF0, 1'b0);
        run_body(0, -1, '0);
        done_falls();

        // start with a new key during GEN is ignored.
        rk = {$urandom, $urandom};
        ref_sched(rk, 1'b0);
        issue_start(rk, 1'b0);
        run_body(25, 5, {$urandom, $urandom});
        done_falls();

        // Back-to-back: new start in the done cycle.
        rk = {$urandom, $urandom};
        ref_sched(rk, 1'b0);
        issue_start(rk, 1'b0);
        run_body(0, -1, '0);
        rk = {$urandom, $urandom};
        ref_sched(rk, 1'b1);
        issue_start(rk, 1'b1);
        run_body(20, -1, '0);
        done_falls();

        // Asynchronous reset while stalled at round 7.
        ref_sched(KEY0, 1'b0);
        issue_start(KEY0, 1'b0);
        subkey_ready = 1'b1;
        n = 0;
        while (round !== 4'd7 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        subkey_ready = 1'b0;
        check("reach_round7", 64'(round), 64'd7);
        repeat (2) @(posedge clk);
        #1;
        check("stall_round", 64'(round), 64'd7);
        check("stall_subkey", 64'(subkey), 64'(exp_ks[7]));
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_round", 64'(round), 64'd0);
        check("abort_subkey", 64'(subkey), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle", 64'(subkey_valid), 64'd0);
        issue_start(KEY0, 1'b0);
        run_body(0, -1, '0);
        done_falls();

        // Random keys and directions.
        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom};
            rd = $urandom_range(1);
            ref_sched(rk, rd);
            issue_start(rk, rd);
            run_body(35, -1, '0);
            done_falls();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key schedule. Loads a 64-bit key, applies PC1, then emits the 16 48-bit round subkeys one per handshake, through PC2. Output order is K1..K16 for encryption or K16..K1 for decryption. Sits between the key input and the round datapath, and feeds the round function one subkey per round.

## Interface

Parameters:
- none; DES widths and tables are fixed.

Ports:
- `clk`  in  1  clock; all registers sample on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  begin a schedule; honoured only in IDLE.
- `decrypt`  in  1  0 = K1..K16, 1 = K16..K1; sampled with `start`.
- `key`  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,...,64 are ignored.
- `busy`  out  1  high from the cycle after an accepted `start` until the final transfer.
- `subkey_valid`  out  1  `subkey` holds a valid round key.
- `subkey_ready`  in  1  the consumer accepts `subkey` this cycle.
- `subkey`  out  [1:48]  PC2(C,D) of the current halves, bit 1 = MSB.
- `round`  out  4  index of the current subkey in emission order, 0..15.
- `done`  out  1  one-cycle pulse after the 16th transfer.

## Operation

- State registers:
  - `C[1:28]` and `D[1:28]`.
  - 4-bit round counter.
  - Latched decrypt flag.
  - FSM with states IDLE and GEN.
- Shift schedule, indexed by key number n = 1..16: S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE + `start`:
  - {C,D} ← PC1(`key`). PC1 is the standard table: C from bits 57,49,...,36; D from bits 63,55,...,4.
  - Encrypt: both halves are loaded already rotated left by S[1] = 1, so the first subkey is K1.
  - Decrypt: halves are loaded unrotated. The total rotation is 28, so C16 = C0 and the first subkey is K16.
  - Round counter ← 0, decrypt flag ← `decrypt`, FSM → GEN.
- GEN:
  - `subkey_valid` = 1.
  - `subkey` = PC2(C,D), combinational from registers. It is stable while stalled.
- Transfer = `subkey_valid` && `subkey_ready`. On a transfer with round r < 15, round ← r+1 and the halves rotate:
  - Encrypt: C and D rotate left by S[r+2].
  - Decrypt: C and D rotate right by S[16−r], so K(n) → K(n−1) uses a right rotation by S[n].
- On a transfer with r = 15: FSM → IDLE, `done` = 1 for the next cycle, and `busy` and `subkey_valid` fall.
- No transfer: all state holds.
- `start` during GEN is ignored, and `key`/`decrypt` changes have no effect. A new `start` is accepted in the same cycle `done` is high, because the FSM is already in IDLE.
- `rst_n` low at any time, including mid-schedule, immediately returns to IDLE and aborts the schedule. No `done` is issued for an aborted schedule.

## Timing

- Reset values:
  - `busy` = 0, `subkey_valid` = 0, `done` = 0, `round` = 0, `subkey` = 48'h0.
  - C and D are cleared, so PC2(0) = 0.
- Latency: `start` sampled at edge t gives `subkey_valid` = 1 with round 0 after edge t, in the same cycle as `busy` rises.
- Throughput: one subkey per cycle while `subkey_ready` = 1. With ready held high, the full schedule takes 16 cycles, and `done` is high in cycle 17 after `start`.
- The rotation and PC2 are single-cycle combinational; there is no pipelining.
- `round` and `subkey` change only on the edge following a transfer.

## Test plan

- Encrypt, key 64'h133457799BBCDFF1, ready held high:
  - round 0 → 48'h1B02EFFC7072, round 1 → 48'h79AED9DBC9E5, round 15 → 48'hCB3D8B0E17F5.
  - `done` pulses exactly one cycle after the 16th transfer.
- Decrypt, same key:
  - round 0 → 48'hCB3D8B0E17F5, round 14 → 48'h79AED9DBC9E5, round 15 → 48'h1B02EFFC7072.
  - All 16 values equal the encrypt sequence reversed.
- Backpressure: ready toggled pseudo-randomly, both directions.
  - Each subkey holds stable across stalls.
  - Exactly 16 transfers occur and the values match the reference order.
- Parity insensitivity: same key with bits 8,16,...,64 inverted (64'h123556789ABCDEF0 ^ pattern) → identical subkey sequence.
- `start` pulsed with a different key during GEN → the sequence continues with the original key. Back-to-back `start` in the `done` cycle → the new schedule starts with no gap.
- `rst_n` asserted at round 7 mid-stall → all outputs read their reset values immediately with no `done`. A following `start` produces round 0 = K1 correctly.
